rv_multicycle_ctrl: RTL and testbench

Parametrised control and sequencing engine for the multicycle RV32 core. It replaces the fixed, single-cycle-latency memory FSM with a req/ack bus handshake, bus-error and timeout detection, and alignment checking. It adds precise traps, single-step debug, load byte-lane alignment/extension and a retired-instruction counter. It sits between the instruction decoder/ALU/register file and the memory system.

---
 rtl/rv_multicycle_ctrl_pkg.sv | 35 +++
 rtl/rv_multicycle_ctrl_if.sv | 24 ++
 rtl/rv_multicycle_ctrl_load_align.sv | 25 ++
 rtl/rv_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control engine: FSM states,
// trap causes, memory-op and access-size codes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd7
  } state_e;

  localparam logic [2:0] CAUSE_NONE          = 3'd0;
  localparam logic [2:0] CAUSE_FETCH_MISALIGN = 3'd1;
  localparam logic [2:0] CAUSE_FETCH_ERR     = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL       = 3'd3;
  localparam logic [2:0] CAUSE_LS_MISALIGN   = 3'd4;
  localparam logic [2:0] CAUSE_LS_ERR        = 3'd5;
  localparam logic [2:0] CAUSE_TIMEOUT       = 3'd6;

  localparam logic [1:0] MEMOP_NONE  = 2'd0;
  localparam logic [1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [1:0] MEMOP_STORE = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Memory bus between the control engine (master) and the memory system (slave).
interface rv_multicycle_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            mem_req;
  logic            mem_we;
  logic [1:0]      mem_size;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic            mem_err;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_size, mem_addr,
    input  mem_ack, mem_err, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_size, mem_addr,
    output mem_ack, mem_err, mem_rdata
  );

endinterface

// File: rtl/rv_multicycle_ctrl_load_align.sv
// Load lane selection: shifts the addressed byte lane down to bit 0 and
// sign- or zero-extends to XLEN according to the access size.
module load_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  import rv_ctrl_pkg::*;

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SIZE_BYTE: data_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Control and sequencing engine for the multicycle RV32 core: fetch/execute
// FSM with req/ack memory handshake, precise traps, single-step and instret.
module rv_multicycle_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     MEM_TIMEOUT = 15,
  parameter int unsigned     CNT_W       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 clear_trap,
  rv_multicycle_ctrl_if.master mem,
  output logic [XLEN-1:0]      instr,
  input  logic                 dec_error,
  input  logic [1:0]           mem_op,
  input  logic [1:0]           ls_size,
  input  logic                 load_unsigned,
  input  logic [XLEN-1:0]      alu_out,
  input  logic [XLEN-1:0]      rv1,
  input  logic [XLEN-1:0]      imm,
  input  logic                 jump,
  input  logic                 jalr,
  input  logic                 branch,
  input  logic                 branch_taken,
  input  logic                 rd_write,
  output logic                 rf_we,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [XLEN-1:0]      pc,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [2:0]           trap_cause,
  output logic [CNT_W-1:0]     instret
);
  import rv_ctrl_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic [XLEN-1:0]  load_q, load_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [7:0]       wait_q, wait_d;

  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  exec_npc;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  pc_plus4;
  logic             timeout;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i    (mem.mem_rdata),
    .offset_i   (result_q[1:0]),
    .size_i     (ls_size),
    .unsigned_i (load_unsigned),
    .data_o     (load_data)
  );

  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = rv1 + imm;
  assign timeout  = (wait_q == WAIT_LAST);

  always_comb begin
    if (jalr)                        exec_npc = {jalr_sum[XLEN-1:1], 1'b0};
    else if (jump)                   exec_npc = pc_q + imm;
    else if (branch && branch_taken) exec_npc = pc_q + imm;
    else                             exec_npc = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      result_q  <= '0;
      npc_q     <= '0;
      load_q    <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      result_q  <= result_d;
      npc_q     <= npc_d;
      load_q    <= load_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    result_d     = result_q;
    npc_d        = npc_q;
    load_d       = load_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    wait_d       = '0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_size = SIZE_BYTE;
    mem.mem_addr = '0;
    rf_we        = 1'b0;
    rf_wdata     = '0;

    case (state_q)
      ST_IDLE: begin
        if (run || step) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_MISALIGN;
        end else begin
          mem.mem_req  = 1'b1;
          mem.mem_size = SIZE_WORD;
          mem.mem_addr = pc_q;
          // err outranks ack, and ack outranks a coincident timeout
          if (mem.mem_err) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_FETCH_ERR;
          end else if (mem.mem_ack) begin
            instr_d = mem.mem_rdata;
            state_d = ST_DECODE;
          end else if (timeout) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        result_d = alu_out;
        npc_d    = exec_npc;
        if (dec_error) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (mem_op != MEMOP_NONE) begin
          if (ls_misaligned(ls_size, alu_out[1:0])) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_LS_MISALIGN;
          end else begin
            state_d = ST_MEM;
          end
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = (mem_op == MEMOP_STORE);
        mem.mem_size = ls_size;
        mem.mem_addr = result_q;
        if (mem.mem_err) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_LS_ERR;
        end else if (mem.mem_ack) begin
          load_d  = load_data;
          state_d = ST_WRITEBACK;
        end else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WRITEBACK: begin
        rf_we = rd_write;
        if (jump)                      rf_wdata = pc_plus4;
        else if (mem_op == MEMOP_LOAD) rf_wdata = load_q;
        else                           rf_wdata = result_q;
        pc_d      = npc_q;
        instret_d = instret_q + CNT_W'(1);
        state_d   = step_mode ? ST_IDLE : ST_FETCH;
      end
      ST_TRAP: begin
        if (clear_trap) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr      = instr_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: table of single-stepped instructions
// against a configurable wait-state memory, plus run-mode and reset sequences.
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0, step_mode = 1'b0, step = 1'b0, clear_trap = 1'b0;
  logic [31:0] instr;
  logic        dec_error = 1'b0;
  logic [1:0]  mem_op = 2'd0, ls_size = 2'd0;
  logic        load_unsigned = 1'b0;
  logic [31:0] alu_out = '0, rv1 = '0, imm = '0;
  logic        jump = 1'b0, jalr = 1'b0, branch = 1'b0, branch_taken = 1'b0, rd_write = 1'b0;
  logic        rf_we;
  logic [31:0] rf_wdata, pc;
  logic [2:0]  state;
  logic        trap;
  logic [2:0]  trap_cause;
  logic [63:0] instret;

  rv_multicycle_ctrl_if #(.XLEN(32)) bus ();

  rv_multicycle_ctrl #(
    .XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(15), .CNT_W(64)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
    .clear_trap(clear_trap), .mem(bus), .instr(instr), .dec_error(dec_error),
    .mem_op(mem_op), .ls_size(ls_size), .load_unsigned(load_unsigned),
    .alu_out(alu_out), .rv1(rv1), .imm(imm), .jump(jump), .jalr(jalr),
    .branch(branch), .branch_taken(branch_taken), .rd_write(rd_write),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .pc(pc), .state(state), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  longint unsigned exp_instret = 0;

  // memory model: ack/err arrive in request cycle (wait+1)
  int          fwait = 0, dwait = 0, rcnt = 0;
  logic        fack = 1'b1, ferr = 1'b0, dack = 1'b1, derr = 1'b0;
  logic [31:0] fword = '0, dword = '0;

  always @(negedge clk) begin
    int          w;
    logic        a, e;
    logic [31:0] d;
    if (bus.mem_req) begin
      if (state == 3'd1) begin w = fwait; a = fack; e = ferr; d = fword; end
      else               begin w = dwait; a = dack; e = derr; d = dword; end
      bus.mem_ack   = (rcnt == w) && a;
      bus.mem_err   = (rcnt == w) && e;
      bus.mem_rdata = (rcnt == w) ? d : 32'h0;
      rcnt++;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_err   = 1'b0;
      bus.mem_rdata = 32'h0;
      rcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mem_op, ls_size;
    logic        lu, jump, jalr, branch, btaken, rd_write, dec_err;
    logic [31:0] alu, rv1, imm, fword, dword;
    int          fwait, dwait;
    logic        fack, ferr, dack, derr;
    logic        trap;
    logic [2:0]  cause;
    int          cycles;
    logic [31:0] pc, wdata;
    logic        mem, iok;
  } vec_t;

  function automatic vec_t base();
    vec_t v;
    v = '{default: 0};
    v.fack = 1'b1; v.dack = 1'b1; v.iok = 1'b1; v.cycles = 4;
    return v;
  endfunction

  task automatic run_one(input int idx, input vec_t v);
    int          cyc, wb_cnt;
    logic        wb_we, mem_seen, mem_we_s;
    logic [31:0] wb_data, mem_addr_s;
    logic [1:0]  mem_size_s;
    string       p;
    p = $sformatf("v%0d", idx);
    mem_op = v.mem_op; ls_size = v.ls_size; load_unsigned = v.lu;
    jump = v.jump; jalr = v.jalr; branch = v.branch; branch_taken = v.btaken;
    rd_write = v.rd_write; dec_error = v.dec_err;
    alu_out = v.alu; rv1 = v.rv1; imm = v.imm;
    fwait = v.fwait; fack = v.fack; ferr = v.ferr; fword = v.fword;
    dwait = v.dwait; dack = v.dack; derr = v.derr; dword = v.dword;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    cyc = 0; wb_cnt = 0; wb_we = 1'b0; wb_data = '0;
    mem_seen = 1'b0; mem_we_s = 1'b0; mem_addr_s = '0; mem_size_s = '0;
    while (state != 3'd0 && state != 3'd7 && cyc < 100) begin
      cyc++;
      if (state == 3'd5) begin wb_cnt++; wb_we = rf_we; wb_data = rf_wdata; end
      if (state == 3'd4 && !mem_seen) begin
        mem_seen = 1'b1; mem_we_s = bus.mem_we; mem_addr_s = bus.mem_addr; mem_size_s = bus.mem_size;
      end
      @(negedge clk);
    end
    if (!v.trap) exp_instret++;
    chk({p, "_cycles"}, 64'(cyc), 64'(v.cycles));
    chk({p, "_state"}, 64'(state), v.trap ? 64'd7 : 64'd0);
    chk({p, "_trap"}, 64'(trap), 64'(v.trap));
    chk({p, "_cause"}, 64'(trap_cause), 64'(v.cause));
    chk({p, "_pc"}, 64'(pc), 64'(v.pc));
    chk({p, "_instret"}, instret, exp_instret);
    chk({p, "_wb_cycles"}, 64'(wb_cnt), v.trap ? 64'd0 : 64'd1);
    if (!v.trap) chk({p, "_rf_we"}, 64'(wb_we), 64'(v.rd_write));
    if (!v.trap && v.rd_write) chk({p, "_rf_wdata"}, 64'(wb_data), 64'(v.wdata));
    chk({p, "_mem_state"}, 64'(mem_seen), 64'(v.mem));
    if (v.mem) begin
      chk({p, "_mem_addr"}, 64'(mem_addr_s), 64'(v.alu));
      chk({p, "_mem_we"}, 64'(mem_we_s), 64'(v.mem_op == 2'd2));
      chk({p, "_mem_size"}, 64'(mem_size_s), 64'(v.ls_size));
    end
    if (v.iok) chk({p, "_instr"}, 64'(instr), 64'(v.fword));
    if (v.trap) begin
      @(negedge clk); clear_trap = 1'b1;
      @(negedge clk); clear_trap = 1'b0;
      chk({p, "_clr_state"}, 64'(state), 64'd0);
      chk({p, "_clr_cause"}, 64'(trap_cause), 64'd0);
    end
  endtask

  vec_t vq[$];
  vec_t v;

  initial begin
    // pc chain starts at 4 after the run-mode ADDI sequence
    v = base(); v.mem_op = 1; v.ls_size = 0; v.alu = 32'h103; v.rd_write = 1; v.dword = 32'h8000_0000;
    v.dwait = 3; v.cycles = 8; v.pc = 32'd8; v.wdata = 32'hFFFF_FF80; v.mem = 1; vq.push_back(v);
    v = base(); v.mem_op = 1; v.ls_size = 0; v.lu = 1; v.alu = 32'h103; v.rd_write = 1; v.dword = 32'h8000_0000;
    v.cycles = 5; v.pc = 32'd12; v.wdata = 32'h0000_0080; v.mem = 1; vq.push_back(v);
    v = base(); v.mem_op = 1; v.ls_size = 1; v.alu = 32'h102; v.rd_write = 1; v.dword = 32'h8001_1234;
    v.cycles = 5; v.pc = 32'd16; v.wdata = 32'hFFFF_8001; v.mem = 1; vq.push_back(v);
    v = base(); v.mem_op = 1; v.ls_size = 2; v.alu = 32'h104; v.rd_write = 1; v.dword = 32'hDEAD_BEEF;
    v.cycles = 5; v.pc = 32'd20; v.wdata = 32'hDEAD_BEEF; v.mem = 1; vq.push_back(v);
    v = base(); v.mem_op = 1; v.ls_size = 2; v.alu = 32'h102; v.rd_write = 1;
    v.trap = 1; v.cause = 4; v.cycles = 3; v.pc = 32'd20; vq.push_back(v);
    v = base(); v.mem_op = 2; v.ls_size = 2; v.alu = 32'h200; v.derr = 1;
    v.trap = 1; v.cause = 5; v.cycles = 4; v.pc = 32'd20; v.mem = 1; vq.push_back(v);
    v = base(); v.mem_op = 2; v.ls_size = 2; v.alu = 32'h204; v.dwait = 1;
    v.cycles = 6; v.pc = 32'd24; v.mem = 1; vq.push_back(v);
    v = base(); v.dec_err = 1; v.rd_write = 1; v.trap = 1; v.cause = 3; v.cycles = 3; v.pc = 32'd24; vq.push_back(v);
    v = base(); v.branch = 1; v.btaken = 1; v.imm = 32'hFFFF_FFF8; v.alu = 32'h1; v.pc = 32'd16; vq.push_back(v);
    v = base(); v.branch = 1; v.btaken = 0; v.imm = 32'd100; v.pc = 32'd20; vq.push_back(v);
    v = base(); v.jump = 1; v.imm = 32'd8; v.alu = 32'hDEAD; v.rd_write = 1; v.wdata = 32'd24; v.pc = 32'd28; vq.push_back(v);
    v = base(); v.jump = 1; v.jalr = 1; v.rv1 = 32'h101; v.imm = 32'h20; v.rd_write = 1;
    v.wdata = 32'd32; v.pc = 32'h120; vq.push_back(v);
    v = base(); v.fack = 0; v.iok = 0; v.trap = 1; v.cause = 6; v.cycles = 15; v.pc = 32'h120; vq.push_back(v);
    v = base(); v.fack = 0; v.ferr = 1; v.fwait = 2; v.iok = 0; v.trap = 1; v.cause = 2; v.cycles = 3;
    v.pc = 32'h120; vq.push_back(v);
    v = base(); v.mem_op = 1; v.ls_size = 2; v.alu = 32'h300; v.rd_write = 1; v.dack = 0;
    v.trap = 1; v.cause = 6; v.cycles = 18; v.pc = 32'h120; v.mem = 1; vq.push_back(v);
    v = base(); v.jump = 1; v.jalr = 1; v.rv1 = 32'h200; v.imm = 32'd2; v.rd_write = 1;
    v.wdata = 32'h124; v.pc = 32'h202; vq.push_back(v);
    v = base(); v.iok = 0; v.trap = 1; v.cause = 1; v.cycles = 1; v.pc = 32'h202; vq.push_back(v);

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_cause", 64'(trap_cause), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    rst = 1'b1;

    // run mode ADDI at pc 0, zero-wait memory: rf_we only in cycle 4
    @(negedge clk);
    fword = 32'h0050_0093; alu_out = 32'd5; rd_write = 1'b1; run = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) chk($sformatf("addi_rf_we_c%0d", c), 64'(rf_we), 64'd0);
      else begin
        chk("addi_state_c4", 64'(state), 64'd5);
        chk("addi_rf_we_c4", 64'(rf_we), 64'd1);
        chk("addi_rf_wdata", 64'(rf_wdata), 64'd5);
        run = 1'b0; step_mode = 1'b1;
      end
    end
    @(negedge clk);
    exp_instret = 1;
    chk("addi_idle", 64'(state), 64'd0);
    chk("addi_pc", 64'(pc), 64'd4);
    chk("addi_instret", instret, 64'd1);
    chk("addi_instr", 64'(instr), 64'h0050_0093);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      v.fword = 32'h0000_0013 | (32'(i) << 7);
      if (!v.iok) v.fword = 32'h0;
      run_one(i, v);
    end

    // asynchronous reset in the middle of a MEM request
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    exp_instret = 0;
    v = base(); v.alu = 32'd7; v.rd_write = 1; v.wdata = 32'd7; v.pc = 32'd4; v.fword = 32'h0070_0093;
    run_one(100, v);
    mem_op = 2'd2; ls_size = 2'd2; alu_out = 32'h40; rd_write = 1'b0; dack = 1'b0; dwait = 0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    for (int n = 0; n < 20 && state != 3'd4; n++) @(negedge clk);
    chk("rstmid_in_mem", 64'(state), 64'd4);
    chk("rstmid_req_before", 64'(bus.mem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_state", 64'(state), 64'd0);
    chk("rstmid_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rstmid_pc", 64'(pc), 64'd0);
    chk("rstmid_instret", instret, 64'd0);
    chk("rstmid_instr", 64'(instr), 64'd0);
    chk("rstmid_rf_we", 64'(rf_we), 64'd0);
    chk("rstmid_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rstmid_trap", 64'(trap), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
